// File: rtl/rtc_sched_pkg.sv
// Shared types and constants for the RTC transaction scheduler:
// requester kinds, FSM states, phase limits and the post-reset init table.
package rtc_sched_pkg;

    typedef enum logic [1:0] {
        KIND_INIT,
        KIND_WRITE,
        KIND_READ
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_GAP
    } state_e;

    localparam logic [3:0]  PHASE_LAST = 4'd11;
    localparam int unsigned INIT_LEN   = 4;

    localparam logic [7:0] INIT_ADDR [INIT_LEN] = '{8'h02, 8'h02, 8'h10, 8'h00};
    localparam logic [7:0] INIT_DATA [INIT_LEN] = '{8'h10, 8'h00, 8'hD2, 8'h00};

endpackage

// File: rtl/rtc_req_latch.sv
// Pending-request flags for init/write/read, the held user write, and the
// fixed-priority pick (init > write > read) presented to the scheduler.
module rtc_req_latch
    import rtc_sched_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_req_i,
    input  logic        wr_req_i,
    input  logic [7:0]  wr_addr_i,
    input  logic [7:0]  wr_data_i,
    input  logic        rd_tick_i,
    input  logic        grant_i,
    output logic        pending_o,
    output kind_e       pick_o,
    output logic [7:0]  wr_addr_o,
    output logic [7:0]  wr_data_o
);

    logic       init_q, init_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        pick_o    = KIND_READ;
        if (init_q)
            pick_o = KIND_INIT;
        else if (wr_q)
            pick_o = KIND_WRITE;
        pending_o = init_q | wr_q | rd_q;

        init_d = init_q;
        rd_d   = rd_q;
        wr_d   = wr_q;
        addr_d = addr_q;
        data_d = data_q;

        // A new init/read request in the grant cycle survives the clear.
        if (grant_i && pick_o == KIND_INIT)
            init_d = 1'b0;
        if (init_req_i)
            init_d = 1'b1;

        if (grant_i && pick_o == KIND_READ)
            rd_d = 1'b0;
        if (rd_tick_i)
            rd_d = 1'b1;

        if (!wr_q && wr_req_i) begin
            wr_d   = 1'b1;
            addr_d = wr_addr_i;
            data_d = wr_data_i;
        end else if (grant_i && pick_o == KIND_WRITE) begin
            wr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_q <= 1'b1;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            init_q <= init_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign wr_addr_o = addr_q;
    assign wr_data_o = data_q;

endmodule

// File: rtl/rtc_transaction_scheduler.sv
// Shares the 12-phase RTC bus counter between init, user-write and read-burst
// requesters; detects end of transaction, captures read bytes, aborts on timeout.
module rtc_transaction_scheduler
    import rtc_sched_pkg::*;
#(
    parameter int unsigned NUM_INIT        = INIT_LEN,
    parameter int unsigned NUM_READ        = 6,
    parameter logic [7:0]  RD_BASE         = 8'h21,
    parameter int unsigned RD_SAMPLE_PHASE = 6,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter int unsigned TIMEOUT         = 511
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_req,
    input  logic        wr_req,
    input  logic [7:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        rd_tick,
    input  logic [3:0]  phase,
    input  logic [7:0]  rd_data,
    output logic        en_write,
    output logic        en_read,
    output logic [7:0]  bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        rd_valid,
    output logic [2:0]  rd_index,
    output logic [7:0]  rd_value,
    output logic        wr_ack,
    output logic        frame_done,
    output logic        timeout_err,
    output logic        busy
);

    state_e     state_q, state_d;
    kind_e      kind_q, kind_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] prev_phase_q;
    logic [7:0] bus_addr_q, bus_addr_d;
    logic [7:0] bus_wdata_q, bus_wdata_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic [9:0] tmo_cnt_q, tmo_cnt_d;
    logic       abort_q, abort_d;
    logic       captured_q, captured_d;
    logic       rd_valid_q;
    logic [2:0] rd_index_q;
    logic [7:0] rd_value_q;

    logic       grant;
    logic       pending;
    kind_e      pick;
    logic [7:0] lat_addr, lat_data;
    logic       capture;
    logic       xfer_done;
    logic       last_entry;
    kind_e      ld_kind;
    logic [2:0] ld_idx;
    logic [7:0] ld_addr, ld_data;

    rtc_req_latch u_req_latch (
        .clk_i      (clk),
        .rst_i      (reset),
        .init_req_i (init_req),
        .wr_req_i   (wr_req),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_tick_i  (rd_tick),
        .grant_i    (grant),
        .pending_o  (pending),
        .pick_o     (pick),
        .wr_addr_o  (lat_addr),
        .wr_data_o  (lat_data)
    );

    // Entry to load next: a fresh pick from IDLE, otherwise the following burst slot.
    always_comb begin
        ld_kind = (state_q == ST_IDLE) ? pick : kind_q;
        ld_idx  = (state_q == ST_IDLE) ? 3'd0 : idx_q + 3'd1;
    end

    always_comb begin
        ld_addr = lat_addr;
        ld_data = lat_data;
        case (ld_kind)
            KIND_READ: begin
                ld_addr = RD_BASE + 8'(ld_idx);
                ld_data = '0;
            end
            KIND_INIT: begin
                ld_addr = INIT_ADDR[ld_idx[1:0]];
                ld_data = INIT_DATA[ld_idx[1:0]];
            end
            default: ;
        endcase
    end

    always_comb begin
        xfer_done = (prev_phase_q == PHASE_LAST) && (phase == 4'd0);
        case (kind_q)
            KIND_READ: last_entry = (idx_q == 3'(NUM_READ - 1));
            KIND_INIT: last_entry = (idx_q == 3'(NUM_INIT - 1));
            default:   last_entry = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        idx_d       = idx_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        gap_cnt_d   = gap_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        abort_d     = abort_q;
        captured_d  = captured_q;
        grant       = 1'b0;
        capture     = 1'b0;
        en_write    = 1'b0;
        en_read     = 1'b0;
        wr_ack      = 1'b0;
        frame_done  = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending) begin
                    grant       = 1'b1;
                    kind_d      = pick;
                    idx_d       = ld_idx;
                    bus_addr_d  = ld_addr;
                    bus_wdata_d = ld_data;
                    tmo_cnt_d   = '0;
                    captured_d  = 1'b0;
                    state_d     = ST_XFER;
                end
            end
            ST_XFER: begin
                en_write = (kind_q != KIND_READ);
                en_read  = (kind_q == KIND_READ);
                if (tmo_cnt_q != '1)
                    tmo_cnt_d = tmo_cnt_q + 10'd1;
                if (kind_q == KIND_READ && !captured_q &&
                    prev_phase_q == 4'(RD_SAMPLE_PHASE) &&
                    phase == 4'(RD_SAMPLE_PHASE + 1)) begin
                    capture    = 1'b1;
                    captured_d = 1'b1;
                end
                if (xfer_done) begin
                    abort_d   = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else if (tmo_cnt_q == 10'(TIMEOUT)) begin
                    timeout_err = 1'b1;
                    abort_d     = 1'b1;
                    gap_cnt_d   = '0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_cnt_d = gap_cnt_q + 4'd1;
                if (gap_cnt_q == 4'(GAP_CYCLES - 1)) begin
                    if (!abort_q && !last_entry) begin
                        idx_d       = ld_idx;
                        bus_addr_d  = ld_addr;
                        bus_wdata_d = ld_data;
                        tmo_cnt_d   = '0;
                        captured_d  = 1'b0;
                        state_d     = ST_XFER;
                    end else begin
                        wr_ack     = !abort_q && (kind_q == KIND_WRITE);
                        frame_done = !abort_q && (kind_q == KIND_READ);
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            kind_q       <= KIND_INIT;
            idx_q        <= '0;
            prev_phase_q <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            gap_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            abort_q      <= 1'b0;
            captured_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_index_q   <= '0;
            rd_value_q   <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            idx_q        <= idx_d;
            prev_phase_q <= phase;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            gap_cnt_q    <= gap_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            abort_q      <= abort_d;
            captured_q   <= captured_d;
            rd_valid_q   <= capture;
            if (capture) begin
                rd_value_q <= rd_data;
                rd_index_q <= idx_q;
            end
        end
    end

    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_index  = rd_index_q;
    assign rd_value  = rd_value_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rtc_transaction_scheduler.sv
// Scoreboard bench for rtc_transaction_scheduler with a behavioural phase counter
// that can be stalled at phase 4 and a read-data source keyed to the read sequence.
module tb_rtc_transaction_scheduler;

    localparam int TMO = 511;

    typedef struct packed {
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] val;
    } rdcap_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_req, wr_req, rd_tick;
    logic [7:0] wr_addr, wr_data;
    logic [3:0] phase;
    logic [7:0] rd_data;
    logic       en_write, en_read;
    logic [7:0] bus_addr, bus_wdata;
    logic       rd_valid;
    logic [2:0] rd_index;
    logic [7:0] rd_value;
    logic       wr_ack, frame_done, timeout_err, busy;

    xfer_t  exp_x[$];
    rdcap_t exp_r[$];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         ack_cnt, fd_cnt, to_cnt;
    int         low_run = 0;
    int         en_run = 0;
    int         last_cmpl = -100;
    int         rd_seq_next = 0;
    bit         had_prev = 1'b0;
    bit         stall = 1'b0;
    logic       en_prev = 1'b0;
    logic [3:0] ph_prev = '0;
    logic [7:0] rd_cur = '0;

    always #5 clk = ~clk;

    rtc_transaction_scheduler dut (
        .clk         (clk),
        .reset       (reset),
        .init_req    (init_req),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_tick     (rd_tick),
        .phase       (phase),
        .rd_data     (rd_data),
        .en_write    (en_write),
        .en_read     (en_read),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .rd_valid    (rd_valid),
        .rd_index    (rd_index),
        .rd_value    (rd_value),
        .wr_ack      (wr_ack),
        .frame_done  (frame_done),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    // Phase counter: advances while enabled, wraps 11->0, returns to 0 when idle.
    always @(posedge clk or posedge reset) begin
        if (reset)
            phase <= 4'd0;
        else if (en_write || en_read) begin
            if (stall && phase == 4'd4)
                phase <= phase;
            else
                phase <= (phase == 4'd11) ? 4'd0 : phase + 4'd1;
        end else
            phase <= 4'd0;
    end

    assign rd_data = (phase == 4'd6 || phase == 4'd7) ? 8'h30 + rd_cur : 8'hEE;

    function automatic logic [39:0] out_vec();
        return {en_write, en_read, bus_addr, bus_wdata, rd_valid, rd_index,
                rd_value, wr_ack, frame_done, timeout_err, busy};
    endfunction

    task automatic tick();
        xfer_t  ex, ox;
        rdcap_t er, orr;
        logic   en;
        @(posedge clk);
        #1;
        cyc++;
        en = en_write | en_read;
        if (en && !en_prev) begin
            n_cmp++;
            if (en_write && en_read) begin
                n_bad++;
                $display("FAIL onehot_en: en_write=%0b en_read=%0b required exactly one", en_write, en_read);
            end
            ox = '{rd: en_read, addr: bus_addr, data: bus_wdata};
            n_cmp++;
            if (exp_x.size() == 0) begin
                n_bad++;
                $display("FAIL xfer_unexpected: got rd=%0b addr=%h data=%h, none expected", ox.rd, ox.addr, ox.data);
            end else begin
                ex = exp_x.pop_front();
                if (ox !== ex) begin
                    n_bad++;
                    $display("FAIL xfer: got rd=%0b addr=%h data=%h required rd=%0b addr=%h data=%h",
                             ox.rd, ox.addr, ox.data, ex.rd, ex.addr, ex.data);
                end
            end
            if (had_prev) begin
                n_cmp++;
                if (low_run < 2) begin
                    n_bad++;
                    $display("FAIL gap: got %0d idle cycles required >= 2", low_run);
                end
            end
            had_prev = 1'b1;
            en_run   = 0;
            if (en_read) begin
                rd_cur = 8'(rd_seq_next);
                rd_seq_next++;
            end
        end
        if (en) begin
            en_run++;
            low_run = 0;
        end else
            low_run++;
        if (en && ph_prev == 4'd11 && phase == 4'd0)
            last_cmpl = cyc;
        ph_prev = phase;
        if (rd_valid) begin
            orr = '{idx: rd_index, val: rd_value};
            n_cmp++;
            if (exp_r.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: got idx=%0d val=%h, none expected", orr.idx, orr.val);
            end else begin
                er = exp_r.pop_front();
                if (orr !== er) begin
                    n_bad++;
                    $display("FAIL rd_capture: got idx=%0d val=%h required idx=%0d val=%h",
                             orr.idx, orr.val, er.idx, er.val);
                end
            end
        end
        if (wr_ack) begin
            ack_cnt++;
            n_cmp++;
            if (cyc - last_cmpl !== 2) begin
                n_bad++;
                $display("FAIL wr_ack_latency: got %0d cycles after 11->0 required 2", cyc - last_cmpl);
            end
        end
        if (frame_done) begin
            fd_cnt++;
            n_cmp++;
            if (cyc - last_cmpl !== 2) begin
                n_bad++;
                $display("FAIL frame_done_latency: got %0d cycles after 11->0 required 2", cyc - last_cmpl);
            end
        end
        if (timeout_err) begin
            to_cnt++;
            n_cmp++;
            if (en_run !== TMO + 1) begin
                n_bad++;
                $display("FAIL timeout_len: got %0d enabled cycles required %0d", en_run, TMO + 1);
            end
        end
        en_prev = en;
    endtask

    task automatic wait_idle(input int max_cycles, input string tag);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < max_cycles) begin
            tick();
            n++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        n_cmp++;
        if (quiet < 4) begin
            n_bad++;
            $display("FAIL %s_idle_wait: still busy after %0d cycles required idle", tag, max_cycles);
        end
    endtask

    task automatic wait_en_write(input int max_cycles);
        int n = 0;
        while (!en_write && n < max_cycles) begin
            tick();
            n++;
        end
    endtask

    task automatic clear_counts();
        ack_cnt = 0;
        fd_cnt  = 0;
        to_cnt  = 0;
    endtask

    task automatic push_init();
        exp_x.push_back('{rd: 1'b0, addr: 8'h02, data: 8'h10});
        exp_x.push_back('{rd: 1'b0, addr: 8'h02, data: 8'h00});
        exp_x.push_back('{rd: 1'b0, addr: 8'h10, data: 8'hD2});
        exp_x.push_back('{rd: 1'b0, addr: 8'h00, data: 8'h00});
    endtask

    task automatic push_read_burst();
        for (int i = 0; i < 6; i++) begin
            exp_x.push_back('{rd: 1'b1, addr: 8'h21 + 8'(i), data: 8'h00});
            exp_r.push_back('{idx: 3'(i), val: 8'h30 + 8'(i)});
        end
    endtask

    task automatic check_empty(input string tag);
        n_cmp++;
        if (exp_x.size() != 0 || exp_r.size() != 0) begin
            n_bad++;
            $display("FAIL %s_outstanding: got %0d xfers %0d reads left required 0 0", tag, exp_x.size(), exp_r.size());
        end
    endtask

    task automatic test_reset();
        clear_counts();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (out_vec() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0", out_vec());
        end
        push_init();
        reset = 1'b0;
        wait_idle(300, "init");
        check_empty("init");
        n_cmp++;
        if (ack_cnt != 0 || fd_cnt != 0) begin
            n_bad++;
            $display("FAIL init_acks: got wr_ack=%0d frame_done=%0d required 0 0", ack_cnt, fd_cnt);
        end
    endtask

    task automatic test_write();
        int n;
        clear_counts();
        exp_x.push_back('{rd: 1'b0, addr: 8'h21, data: 8'h45});
        wr_addr = 8'h21;
        wr_data = 8'h45;
        wr_req  = 1'b1;
        tick();
        wr_req = 1'b0;
        n = 1;
        while (!en_write && n < 2) begin
            tick();
            n++;
        end
        n_cmp++;
        if (en_write !== 1'b1) begin
            n_bad++;
            $display("FAIL write_start: got en_write=%0b after %0d cycles required 1", en_write, n);
        end
        wait_idle(100, "write");
        check_empty("write");
        n_cmp++;
        if (ack_cnt != 1) begin
            n_bad++;
            $display("FAIL write_ack_count: got %0d required 1", ack_cnt);
        end
    endtask

    task automatic test_read();
        clear_counts();
        rd_seq_next = 0;
        push_read_burst();
        rd_tick = 1'b1;
        tick();
        rd_tick = 1'b0;
        wait_idle(400, "read");
        check_empty("read");
        n_cmp++;
        if (fd_cnt != 1 || ack_cnt != 0) begin
            n_bad++;
            $display("FAIL read_frame_done: got frame_done=%0d wr_ack=%0d required 1 0", fd_cnt, ack_cnt);
        end
    endtask

    task automatic test_priority();
        clear_counts();
        rd_seq_next = 0;
        push_init();
        exp_x.push_back('{rd: 1'b0, addr: 8'h5A, data: 8'hA5});
        push_read_burst();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        wait_en_write(10);
        wr_addr = 8'h5A;
        wr_data = 8'hA5;
        wr_req  = 1'b1;
        rd_tick = 1'b1;
        tick();
        wr_req  = 1'b0;
        rd_tick = 1'b0;
        repeat (3) tick();
        wr_addr = 8'h77;
        wr_data = 8'h88;
        wr_req  = 1'b1;
        tick();
        wr_req = 1'b0;
        wait_idle(800, "priority");
        check_empty("priority");
        n_cmp++;
        if (ack_cnt != 1 || fd_cnt != 1) begin
            n_bad++;
            $display("FAIL priority_acks: got wr_ack=%0d frame_done=%0d required 1 1", ack_cnt, fd_cnt);
        end
    endtask

    task automatic test_back_to_back();
        clear_counts();
        exp_x.push_back('{rd: 1'b0, addr: 8'h31, data: 8'h01});
        exp_x.push_back('{rd: 1'b0, addr: 8'h32, data: 8'h02});
        wr_addr = 8'h31;
        wr_data = 8'h01;
        wr_req  = 1'b1;
        tick();
        wr_req = 1'b0;
        wait_en_write(10);
        wr_addr = 8'h32;
        wr_data = 8'h02;
        wr_req  = 1'b1;
        tick();
        wr_req = 1'b0;
        wait_idle(200, "b2b");
        check_empty("b2b");
        n_cmp++;
        if (ack_cnt != 2) begin
            n_bad++;
            $display("FAIL b2b_ack_count: got %0d required 2", ack_cnt);
        end
    endtask

    task automatic test_timeout();
        clear_counts();
        stall = 1'b1;
        exp_x.push_back('{rd: 1'b1, addr: 8'h21, data: 8'h00});
        rd_tick = 1'b1;
        tick();
        rd_tick = 1'b0;
        wait_idle(800, "timeout");
        stall = 1'b0;
        check_empty("timeout");
        n_cmp++;
        if (to_cnt != 1 || fd_cnt != 0) begin
            n_bad++;
            $display("FAIL timeout_pulses: got timeout_err=%0d frame_done=%0d required 1 0", to_cnt, fd_cnt);
        end
        n_cmp++;
        if ({en_write, en_read} !== 2'b00) begin
            n_bad++;
            $display("FAIL timeout_enables: got %b required 00", {en_write, en_read});
        end
    endtask

    task automatic test_reset_mid_read();
        int n = 0;
        clear_counts();
        rd_seq_next = 0;
        exp_x.push_back('{rd: 1'b1, addr: 8'h21, data: 8'h00});
        rd_tick = 1'b1;
        tick();
        rd_tick = 1'b0;
        while (!(en_read && phase == 4'd7) && n < 40) begin
            tick();
            n++;
        end
        n_cmp++;
        if (!(en_read && phase == 4'd7)) begin
            n_bad++;
            $display("FAIL reset_mid_reach: got en_read=%0b phase=%0d required 1 7", en_read, phase);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_vec() !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h required 0", out_vec());
        end
        push_init();
        tick();
        tick();
        reset = 1'b0;
        wait_idle(300, "reinit");
        check_empty("reinit");
        n_cmp++;
        if (fd_cnt != 0 || ack_cnt != 0) begin
            n_bad++;
            $display("FAIL reset_mid_acks: got frame_done=%0d wr_ack=%0d required 0 0", fd_cnt, ack_cnt);
        end
    endtask

    initial begin
        reset    = 1'b1;
        init_req = 1'b0;
        wr_req   = 1'b0;
        rd_tick  = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        test_reset();
        test_write();
        test_read();
        test_priority();
        test_back_to_back();
        test_timeout();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rtc_transaction_scheduler.md
Name: rtc_transaction_scheduler

Overview:
- Sequences the RTC bus phase counter (12-phase transaction timer, phase 0..11) and shares it between three requesters: the post-reset init sequence, user writes and periodic time reads.
- Drives the counter's write/read enables and the current address/data.
- Detects end of transaction from the phase value and captures read data.
- Sits between the user/menu FSM and the phase counter / bus driver.

Parameters:
NUM_INIT, 4, number of entries in the init write table
NUM_READ, 6, registers read per read burst (addresses RD_BASE..RD_BASE+NUM_READ-1)
RD_BASE, 8'h21, first register address of the read burst
RD_SAMPLE_PHASE, 6, phase during which read data is valid on rd_data
GAP_CYCLES, 2, idle cycles with both enables low between transactions
TIMEOUT, 511, maximum cycles in one transaction before abort

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-high
init_req  in  1  pulse; request re-run of the init sequence
wr_req  in  1  pulse; request one user write
wr_addr  in  8  write address, sampled with wr_req
wr_data  in  8  write data, sampled with wr_req
rd_tick  in  1  pulse; request one read burst
phase  in  4  current phase from the phase counter
rd_data  in  8  bus read data
en_write  out  1  write enable to the phase counter
en_read  out  1  read enable to the phase counter
bus_addr  out  8  address of the current transaction
bus_wdata  out  8  write data of the current transaction
rd_valid  out  1  one-cycle pulse; rd_value/rd_index valid
rd_index  out  3  index 0..NUM_READ-1 of the captured register
rd_value  out  8  captured read byte
wr_ack  out  1  one-cycle pulse; user write completed
frame_done  out  1  one-cycle pulse; full read burst completed
timeout_err  out  1  one-cycle pulse; transaction aborted
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; prev_phase 0.
  - init_pending=1, so the init sequence runs automatically after reset.
  - wr_pending=0, rd_pending=0.
- Asserting reset mid-operation aborts immediately. No ack is issued. The init sequence re-runs after release.
- Request latching:
  - init_req sets init_pending.
  - wr_req is accepted only when wr_pending=0; it latches wr_addr/wr_data. While a write is pending, further wr_req are ignored.
  - rd_tick sets rd_pending; repeated ticks merge.
- FSM states: IDLE, XFER, GAP. A kind register holds INIT, WRITE or READ. An idx register holds the burst position.
- In IDLE:
  - Priority is init > write > read.
  - The winner clears its pending flag, sets kind, sets idx=0 and loads bus_addr/bus_wdata.
  - Next cycle the FSM enters XFER.
- In XFER:
  - en_write=1 for INIT/WRITE; en_read=1 for READ. Exactly one enable is high.
  - The enable is held constant until completion.
- Completion: prev_phase==11 and phase==0, evaluated in XFER only. On completion:
  - The FSM enters GAP and both enables drop. The counter uses the low enables to return to phase 0.
- GAP lasts GAP_CYCLES cycles. Then:
  - If the burst has entries left (INIT: idx<NUM_INIT-1; READ: idx<NUM_READ-1), idx increments, the next addr/data loads and the FSM re-enters XFER.
  - Otherwise the FSM returns to IDLE. WRITE is always a single entry.
- Bursts are not preemptible. Requests arriving during a burst stay pending.
- Acks:
  - wr_ack pulses on the GAP->IDLE cycle of a WRITE.
  - frame_done pulses on the GAP->IDLE cycle of a READ burst.
- Read capture: in XFER with kind READ, when prev_phase==RD_SAMPLE_PHASE and phase==RD_SAMPLE_PHASE+1:
  - rd_data is registered into rd_value and idx into rd_index.
  - rd_valid is high for exactly the next cycle.
  - Exactly one capture occurs per read transaction.
- Addresses:
  - READ: bus_addr = RD_BASE+idx, modulo 256.
  - INIT: from the package table. bus_wdata is 0 for reads.
- Timeout: an XFER cycle counter (10 bits, saturating) starts at 0 on XFER entry. Reaching TIMEOUT:
  - pulses timeout_err and drops the enables;
  - enters GAP, then IDLE; the rest of the burst is discarded;
  - no wr_ack or frame_done is issued; the pending flag is not restored.
- If phase jumps to 0 from any value other than 11, it is not treated as completion.

Decomposition:
- Package rtc_sched_pkg holds:
  - the kind enum (INIT/WRITE/READ);
  - the FSM state enum;
  - PHASE_LAST=11;
  - INIT_ADDR/INIT_DATA tables: {02:10},{02:00},{10:D2},{00:00}.
- One sub-module, rtc_req_latch, holds the three pending flags, the write address/data hold registers and the priority pick.

Test Plan:
- Reset release with a phase model -> 4 INIT writes, addrs 02,02,10,00, data 10,00,D2,00; en_write low for ≥2 cycles between them; busy falls afterwards.
- wr_req (addr 8'h21, data 8'h45) in IDLE -> en_write high within 2 cycles; bus_addr=21, bus_wdata=45; wr_ack pulses once, 2 cycles after phase 11->0.
- rd_tick, model drives rd_data=idx+8'h30 in phase 6 -> 6 rd_valid pulses, rd_index 0..5, rd_value 30..35, addrs 21..26; then one frame_done.
- wr_req and rd_tick in the same cycle during an INIT burst -> INIT completes, then WRITE, then READ burst; the second wr_req during the pending write is dropped (single wr_ack).
- Phase model stalls at phase 4 -> timeout_err pulses after 511 XFER cycles; enables low; IDLE; no frame_done.
- Assert reset at phase 7 of a read -> all outputs 0 within the same cycle; INIT reruns after release; no rd_valid for the aborted read.
